ft245_tx_arbiter: RTL and testbench
===================================

Name: ft245_tx_arbiter

Overview:
Shares the FT245 FIFO interface's simple TX port (tx_data_si / tx_rdy_si / tx_ack_si) between NUM_REQ byte-stream requesters, for example status, echo and sample streams. Arbitration is round-robin at packet granularity: a grant is held until the requester's last byte, or until an idle timeout expires. A one-byte holding register drives the simple interface. The block sits between the application sources and the FT245 FIFO interface instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 1024, consecutive cycles with the granted requester's valid low that force grant release; 0 disables the timeout.
GID_W, $clog2(NUM_REQ), grant index width (derived localparam).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous assert, active-low.
req_data  in  8*NUM_REQ  byte from requester i at [8i+7:8i].
req_valid  in  NUM_REQ  requester i has a byte available.
req_last  in  NUM_REQ  byte on req_data[i] is the last of its packet.
req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
tx_data_si  out  8  byte to the FT245 interface.
tx_rdy_si  out  1  holding register full.
tx_ack_si  in  1  one-cycle pulse from the FT245 interface: byte taken.
grant_id  out  GID_W  current or last granted requester.
busy  out  1  a packet is in progress (state BUSY).
timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, tx_data_si=0, tx_rdy_si=0, req_ack=0, grant_id=NUM_REQ-1 (so requester 0 wins first), busy=0, timeout_err=0, idle counter=0. A reset mid-packet drops any held byte; the FT245 side is reset together with this block.
- All outputs are registered; req_ack and timeout_err default to 0 every cycle.
- Holding register:
  - "free" = tx_rdy_si==0 or tx_ack_si==1 in this cycle.
  - tx_ack_si clears tx_rdy_si unless a new byte is loaded in the same cycle; in that case tx_rdy_si stays 1 and tx_data_si takes the new byte.
  - tx_ack_si while tx_rdy_si==0 is ignored.
- IDLE:
  - If any req_valid is high, select the first index i with req_valid[i]=1, searching from grant_id+1 modulo NUM_REQ.
  - Then grant_id<=i, busy<=1, idle counter<=0, go to BUSY.
  - No byte is loaded in IDLE; arbitration costs 1 cycle.
- BUSY, with g=grant_id:
  - If req_valid[g] and the holding register is free: tx_data_si<=req_data[g], tx_rdy_si<=1, req_ack[g] pulses for 1 cycle, idle counter<=0.
  - If that byte also has req_last[g]=1: busy<=0, go to IDLE. grant_id keeps g, so g has lowest priority next.
  - If req_valid[g]=0: idle counter increments. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1, go to IDLE, busy<=0, timeout_err pulses. The held byte, if any, is still delivered.
  - Valid high but the register not free: hold, and do not count toward the timeout.
- Non-granted requesters never receive req_ack. Their req_valid/req_data must stay stable until acked.
- Latency:
  - req_valid rising (arbiter idle) to tx_rdy_si=1: 2 cycles. req_ack pulses in the same edge that raises tx_rdy_si.
  - Back-to-back packets: the next packet's first byte can be loaded 1 cycle after the previous last byte was accepted.
- The simple interface never sees tx_rdy_si drop without a tx_ack_si (except at reset).
- Simultaneous events:
  - Timeout expiry and new valid in the same cycle: the byte is accepted, and the counter reset wins.
  - req_last on a single-byte packet: BUSY lasts exactly 1 cycle.

Decomposition:
- Shared package ft245_pkg: state encodings (ST_IDLE, ST_BUSY) and the byte width constant (8).
- One natural sub-module, rr_priority_pick: combinational round-robin first-one search from grant_id+1 over NUM_REQ bits. It is reusable for the future RX demux.

Test Plan:
- Reset, then a single requester: req0 sends a 3-byte packet 0x11,0x22,0x33(last). tx_ack_si is returned 4 cycles after each tx_rdy_si. Expected: bytes appear in order, 3 req_ack[0] pulses, busy falls after 0x33 is loaded, grant_id=0.
- Fairness: req0..req3 all continuously valid with 2-byte packets. Expected: packets are granted in order 0,1,2,3,0 and never interleaved within a packet.
- Back-pressure: hold tx_ack_si low for 50 cycles while req1 is valid. Expected: tx_rdy_si stays 1, tx_data_si is stable, no extra req_ack, no timeout_err.
- Timeout: TIMEOUT_CYCLES=16; req2 sends one non-last byte then drops valid, while req3 is valid. Expected: timeout_err pulses 16 cycles later, then req3 is granted. The req2 byte was already delivered once.
- Same-cycle ack and load: requester streaming while tx_ack_si arrives. Expected: tx_rdy_si stays 1 with the next byte loaded in the same cycle, and no byte is lost or duplicated (check with a 256-byte counting pattern).
- Asynchronous reset mid-packet: assert rst_n low between edges. Expected: tx_rdy_si, busy and req_ack are 0 immediately, and after release requester 0 has first priority.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 FIFO-interface blocks (TX arbiter, future RX demux).
package ft245_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit searching upward from
// last_i+1 and wrapping, so last_i itself has the lowest priority.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             found_o,
  output logic [IDX_W-1:0] pick_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    pick_o  = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_i) + k) % N);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        pick_o  = cand;
      end
    end
  end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the FT245 simple TX port between
// NUM_REQ byte streams through a one-byte holding register.
module ft245_tx_arbiter
  import ft245_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int GID_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [BYTE_W-1:0]         tx_data_si,
  output logic                      tx_rdy_si,
  input  logic                      tx_ack_si,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GID_W-1:0] GID_RST  = GID_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [GID_W-1:0]    grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_rdy_q, tx_rdy_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic                tmo_q, tmo_d;

  logic [BYTE_W-1:0]   req_byte [NUM_REQ];
  logic                pick_found;
  logic [GID_W-1:0]    pick_idx;
  logic                g_valid;
  logic                g_last;
  logic [BYTE_W-1:0]   g_data;
  logic                hold_free;
  logic                load;
  logic                timeout_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = req_data[BYTE_W*i +: BYTE_W];
  end

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (GID_W)
  ) u_pick (
    .req_i   (req_valid),
    .last_i  (grant_q),
    .found_o (pick_found),
    .pick_o  (pick_idx)
  );

  assign g_valid   = req_valid[grant_q];
  assign g_last    = req_last[grant_q];
  assign g_data    = req_byte[grant_q];
  // An ack in this cycle empties the register, so a new byte may replace it on the same edge.
  assign hold_free = !tx_rdy_q || tx_ack_si;
  assign load      = (state_q == ST_BUSY) && g_valid && hold_free;
  // Valid-high-but-stalled cycles never reach this: only an absent source times out.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == ST_BUSY) && !g_valid
                       && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= GID_RST;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_rdy_q  <= 1'b0;
      req_ack_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
      req_ack_q <= req_ack_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_found) state_d = ST_BUSY;
      ST_BUSY: if ((load && g_last) || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_rdy_d  = tx_rdy_q & ~tx_ack_si;
    req_ack_d = '0;
    tmo_d     = 1'b0;
    busy_d    = (state_d == ST_BUSY);
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (load) begin
          tx_data_d          = g_data;
          tx_rdy_d           = 1'b1;
          req_ack_d[grant_q] = 1'b1;
          cnt_d              = '0;
        end else if (!g_valid) begin
          if (timeout_hit) begin
            tmo_d = 1'b1;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign req_ack     = req_ack_q;
  assign tx_data_si  = tx_data_q;
  assign tx_rdy_si   = tx_rdy_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Bench for ft245_tx_arbiter: cycle vector table plus source/sink models for
// multi-cycle scenarios (fairness, back-pressure, timeout, streaming, reset).
module tb_ft245_tx_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_valid, req_last, req_ack;
  logic [7:0]      tx_data_si;
  logic            tx_rdy_si, tx_ack_si;
  logic [1:0]      grant_id;
  logic            busy, timeout_err;

  always #5 clk = ~clk;

  // Table-driven and model-driven stimulus are muxed onto the DUT inputs.
  logic [8*NR-1:0] t_data = '0;
  logic [NR-1:0]   t_valid = '0, t_last = '0;
  logic            t_ack = 1'b0;
  logic [8*NR-1:0] e_data;
  logic [NR-1:0]   e_valid, e_last;
  logic            e_ack;
  logic            env_en = 1'b0;
  logic            sink_en = 1'b0;

  assign req_data  = env_en ? e_data  : t_data;
  assign req_valid = env_en ? e_valid : t_valid;
  assign req_last  = env_en ? e_last  : t_last;
  assign tx_ack_si = env_en ? e_ack   : t_ack;

  ft245_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ack     (req_ack),
    .tx_data_si  (tx_data_si),
    .tx_rdy_si   (tx_rdy_si),
    .tx_ack_si   (tx_ack_si),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- source / sink models ----------------
  int         src_total [NR];
  int         src_pkt   [NR];
  logic [7:0] src_base  [NR];
  logic [7:0] src_step  [NR];
  int         src_idx   [NR];
  int         ack_cnt   [NR];
  int         sink_delay = 0;
  int         sink_cnt, tmo_cnt, bad_ack, overlap_cnt, cyc, ack2_cyc, tmo_cyc;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!env_en) begin
      for (int i = 0; i < NR; i++) begin
        src_idx[i] = 0;
        ack_cnt[i] = 0;
      end
      e_valid = '0; e_last = '0; e_data = '0; e_ack = 1'b0;
      cap.delete();
      tmo_cnt = 0; bad_ack = 0; overlap_cnt = 0; cyc = 0;
      ack2_cyc = -1; tmo_cyc = -1; sink_cnt = 0;
    end else begin
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (req_ack[i]) begin
          ack_cnt[i]++;
          src_idx[i]++;
          if (int'(grant_id) != i) bad_ack++;
          if (i == 2 && ack2_cyc < 0) ack2_cyc = cyc;
        end
      end
      if (timeout_err) begin
        tmo_cnt++;
        if (tmo_cyc < 0) tmo_cyc = cyc;
      end
      if (e_ack && tx_rdy_si && req_ack != '0) overlap_cnt++;
      for (int i = 0; i < NR; i++) begin
        e_valid[i]       = src_idx[i] < src_total[i];
        e_last[i]        = ((src_idx[i] + 1) % src_pkt[i]) == 0;
        e_data[8*i +: 8] = src_base[i] + 8'(src_idx[i]) * src_step[i];
      end
      if (sink_en && tx_rdy_si) begin
        if (sink_cnt >= sink_delay) begin
          e_ack = 1'b1;
          cap.push_back(tx_data_si);
          sink_cnt = 0;
        end else begin
          e_ack = 1'b0;
          sink_cnt++;
        end
      end else begin
        e_ack = 1'b0;
        sink_cnt = 0;
      end
    end
  end

  task automatic start_test();
    env_en = 1'b0;
    sink_en = 1'b0;
    sink_delay = 0;
    for (int i = 0; i < NR; i++) begin
      src_total[i] = 0; src_pkt[i] = 1; src_base[i] = 8'h00; src_step[i] = 8'h01;
    end
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wait_cap(input int n, input int budget, input string name);
    int b;
    b = budget;
    while (cap.size() < n && b > 0) begin
      @(posedge clk);
      b--;
    end
    if (cap.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_wait: captured %0d bytes, expected %0d", name, cap.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_cap(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    check({name, "_len"}, cap.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < cap.size(); k++) begin
      if (cap[k] !== exp_q[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    if (bad != 0)
      $display("first byte difference at index %0d: got 0x%0h, expected 0x%0h",
               first, cap[first], exp_q[first]);
    check({name, "_bytes_wrong"}, bad, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [NR-1:0] valid;
    logic [NR-1:0] last;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic          ack;
    logic          rdy;
    logic [7:0]    data;
    logic [NR-1:0] rack;
    logic          bsy;
    logic [1:0]    gnt;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [7:0] d0,
                              input logic [7:0] d1, input logic a, input logic r,
                              input logic [7:0] dt, input logic [3:0] ra, input logic b,
                              input logic [1:0] g);
    vec_t x;
    x.valid = v; x.last = l; x.d0 = d0; x.d1 = d1; x.ack = a;
    x.rdy = r; x.data = dt; x.rack = ra; x.bsy = b; x.gnt = g;
    return x;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    //                 valid  last   d0     d1     ack | rdy data   rack   busy gnt
    vecs[0]  = mk(4'b0000, 4'b0000, 8'h00, 8'h00, 0,   0, 8'h00, 4'b0000, 0, 2'd3);
    vecs[1]  = mk(4'b0001, 4'b0000, 8'h11, 8'h00, 0,   0, 8'h00, 4'b0000, 1, 2'd0);
    vecs[2]  = mk(4'b0001, 4'b0000, 8'h11, 8'h00, 0,   1, 8'h11, 4'b0001, 1, 2'd0);
    vecs[3]  = mk(4'b0001, 4'b0000, 8'h22, 8'h00, 0,   1, 8'h11, 4'b0000, 1, 2'd0);
    vecs[4]  = mk(4'b0001, 4'b0000, 8'h22, 8'h00, 1,   1, 8'h22, 4'b0001, 1, 2'd0);
    vecs[5]  = mk(4'b0001, 4'b0001, 8'h33, 8'h00, 1,   1, 8'h33, 4'b0001, 0, 2'd0);
    vecs[6]  = mk(4'b0000, 4'b0000, 8'h00, 8'h00, 0,   1, 8'h33, 4'b0000, 0, 2'd0);
    vecs[7]  = mk(4'b0000, 4'b0000, 8'h00, 8'h00, 1,   0, 8'h33, 4'b0000, 0, 2'd0);
    vecs[8]  = mk(4'b0000, 4'b0000, 8'h00, 8'h00, 1,   0, 8'h33, 4'b0000, 0, 2'd0);
    vecs[9]  = mk(4'b0011, 4'b0011, 8'h44, 8'hA1, 0,   0, 8'h33, 4'b0000, 1, 2'd1);
    vecs[10] = mk(4'b0011, 4'b0011, 8'h44, 8'hA1, 0,   1, 8'hA1, 4'b0010, 0, 2'd1);
    vecs[11] = mk(4'b0001, 4'b0001, 8'h44, 8'h00, 1,   0, 8'hA1, 4'b0000, 1, 2'd0);
    vecs[12] = mk(4'b0001, 4'b0001, 8'h44, 8'h00, 0,   1, 8'h44, 4'b0001, 0, 2'd0);
    vecs[13] = mk(4'b0000, 4'b0000, 8'h00, 8'h00, 1,   0, 8'h44, 4'b0000, 0, 2'd0);
    for (int i = 0; i < NR; i++) begin
      src_total[i] = 0; src_pkt[i] = 1; src_base[i] = 8'h00; src_step[i] = 8'h01;
    end

    // Power-on asynchronous reset.
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx_rdy", tx_rdy_si, 0);
    check("rst_tx_data", tx_data_si, 8'h00);
    check("rst_req_ack", req_ack, 0);
    check("rst_grant", grant_id, 3);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      t_valid = vecs[r].valid;
      t_last  = vecs[r].last;
      t_data  = {16'h0000, vecs[r].d1, vecs[r].d0};
      t_ack   = vecs[r].ack;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_tx_rdy", r), tx_rdy_si, vecs[r].rdy);
      check($sformatf("row%0d_tx_data", r), tx_data_si, vecs[r].data);
      check($sformatf("row%0d_req_ack", r), req_ack, vecs[r].rack);
      check($sformatf("row%0d_busy", r), busy, vecs[r].bsy);
      check($sformatf("row%0d_grant", r), grant_id, vecs[r].gnt);
      check($sformatf("row%0d_timeout", r), timeout_err, 0);
    end
    @(negedge clk);
    t_valid = '0; t_last = '0; t_ack = 1'b0;

    // Single requester, 3-byte packet, slow sink.
    start_test();
    src_total[0] = 3; src_pkt[0] = 3; src_base[0] = 8'h11; src_step[0] = 8'h11;
    sink_en = 1'b1; sink_delay = 3;
    env_en = 1'b1;
    wait_cap(3, 200, "single");
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_cap("single");
    check("single_ack_cnt", ack_cnt[0], 3);
    check("single_busy_end", busy, 0);
    check("single_grant_end", grant_id, 0);
    check("single_foreign_ack", bad_ack, 0);

    // Fairness: all four requesters backlogged with 2-byte packets.
    start_test();
    src_total[0] = 4; src_pkt[0] = 2; src_base[0] = 8'h00;
    src_total[1] = 2; src_pkt[1] = 2; src_base[1] = 8'h40;
    src_total[2] = 2; src_pkt[2] = 2; src_base[2] = 8'h80;
    src_total[3] = 2; src_pkt[3] = 2; src_base[3] = 8'hC0;
    sink_en = 1'b1;
    env_en = 1'b1;
    wait_cap(10, 300, "fair");
    exp_q = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h80, 8'h81, 8'hC0, 8'hC1, 8'h02, 8'h03};
    check_cap("fair");
    check("fair_foreign_ack", bad_ack, 0);
    check("fair_timeouts", tmo_cnt, 0);

    // Back-pressure: sink withholds tx_ack_si for 50 cycles.
    start_test();
    src_total[1] = 2; src_pkt[1] = 2; src_base[1] = 8'h55;
    env_en = 1'b1;
    k = 0;
    while (!tx_rdy_si && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_first_rdy", tx_rdy_si, 1);
    k = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (tx_rdy_si !== 1'b1 || tx_data_si !== 8'h55) k++;
    end
    check("bp_unstable_cycles", k, 0);
    check("bp_ack_cnt", ack_cnt[1], 1);
    check("bp_timeouts", tmo_cnt, 0);
    sink_en = 1'b1;
    wait_cap(2, 100, "bp");
    exp_q = '{8'h55, 8'h56};
    check_cap("bp");

    // Timeout: req2 stalls mid-packet while req3 waits.
    start_test();
    src_total[2] = 1; src_pkt[2] = 4; src_base[2] = 8'h77;
    src_total[3] = 2; src_pkt[3] = 2; src_base[3] = 8'h90;
    sink_en = 1'b1;
    env_en = 1'b1;
    wait_cap(3, 200, "tmo");
    exp_q = '{8'h77, 8'h90, 8'h91};
    check_cap("tmo");
    check("tmo_pulses", tmo_cnt, 1);
    check("tmo_delay", tmo_cyc - ack2_cyc, TMO);
    check("tmo_req2_acks", ack_cnt[2], 1);
    check("tmo_req3_acks", ack_cnt[3], 2);
    check("tmo_foreign_ack", bad_ack, 0);

    // Streaming 256-byte counting pattern with same-cycle ack and load.
    start_test();
    src_total[0] = 256; src_pkt[0] = 16; src_base[0] = 8'h00;
    sink_en = 1'b1;
    env_en = 1'b1;
    wait_cap(256, 1000, "stream");
    for (int b = 0; b < 256; b++) exp_q.push_back(8'(b));
    check_cap("stream");
    check("stream_ack_cnt", ack_cnt[0], 256);
    check("stream_overlap_seen", overlap_cnt > 0, 1);

    // Asynchronous reset in the middle of a packet.
    start_test();
    src_total[0] = 4; src_pkt[0] = 4; src_base[0] = 8'hE0;
    env_en = 1'b1;
    k = 0;
    while (!(tx_rdy_si && busy) && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("arst_pre_active", tx_rdy_si & busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx_rdy", tx_rdy_si, 0);
    check("arst_busy", busy, 0);
    check("arst_req_ack", req_ack, 0);
    check("arst_grant", grant_id, 3);
    env_en = 1'b0;
    @(negedge clk);
    #1;
    src_total[0] = 1; src_pkt[0] = 1; src_base[0] = 8'hB0;
    src_total[1] = 1; src_pkt[1] = 1; src_base[1] = 8'hB1;
    sink_en = 1'b1;
    env_en = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("arst_first_grant", grant_id, 0);
    wait_cap(2, 100, "arst");
    exp_q = '{8'hB0, 8'hB1};
    check_cap("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
